// File: rtl/clk_reset_seq.sv
// PLL-lock qualified reset sequencer with a fractional-rate clock-enable strobe.
// Optional macro BTN_DEBOUNCE_EN inserts a DEBOUNCE_CYCLES filter on the reset button.
module clk_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CE_NUM             = 1,
  parameter int CE_DEN             = 54,
  parameter int DEBOUNCE_CYCLES    = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       btn_rst_n,
  output logic       sys_rst_n,
  output logic       ce,
  output logic [1:0] seq_state
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int ACC_W   = $clog2(CE_DEN) + 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [ACC_W-1:0] CE_NUM_W  = ACC_W'(CE_NUM);
  localparam logic [ACC_W-1:0] CE_DEN_W  = ACC_W'(CE_DEN);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic             lock_meta_r, lock_s;
  logic             btn_meta_r, btn_s;
  logic             btn_f_s;
  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s, sum_s;
  logic             ce_r, ce_nxt_s;
  logic             sys_rst_n_r;

  // Two-flop synchronizers for the asynchronous lock and button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_r <= 1'b0;
      lock_s      <= 1'b0;
      btn_meta_r  <= 1'b1;
      btn_s       <= 1'b1;
    end else begin
      lock_meta_r <= pll_lock;
      lock_s      <= lock_meta_r;
      btn_meta_r  <= btn_rst_n;
      btn_s       <= btn_meta_r;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt_r;
  logic             btn_filt_r;

  // Button filter: level follows btn_s only after a full run of identical samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_r  <= {DEB_W{1'b0}};
      btn_filt_r <= 1'b1;
    end else if (btn_s == btn_filt_r) begin
      deb_cnt_r  <= {DEB_W{1'b0}};
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_cnt_r  <= {DEB_W{1'b0}};
      btn_filt_r <= btn_s;
    end else begin
      deb_cnt_r  <= deb_cnt_r + DEB_W'(1);
    end
  end

  assign btn_f_s = btn_filt_r;
`else
  assign btn_f_s = btn_s;
`endif

  // Sequencer next state; lock loss outranks the button everywhere
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (lock_s) begin
          state_nxt_s = STABLE;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == LOCK_LAST) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (!btn_f_s) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == HOLD_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
        end else if (!btn_f_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Phase accumulator; keyed on the next state so ce lines up with the state it belongs to
  always_comb begin
    sum_s     = acc_r + CE_NUM_W;
    acc_nxt_s = {ACC_W{1'b0}};
    ce_nxt_s  = 1'b0;
    if ((state_nxt_s == HOLD) || (state_nxt_s == RUN)) begin
      if (sum_s >= CE_DEN_W) begin
        acc_nxt_s = sum_s - CE_DEN_W;
        ce_nxt_s  = 1'b1;
      end else begin
        acc_nxt_s = sum_s;
        ce_nxt_s  = 1'b0;
      end
    end else begin
      acc_nxt_s = {ACC_W{1'b0}};
      ce_nxt_s  = 1'b0;
    end
  end

  // State, counter, accumulator and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= WAIT_LOCK;
      cnt_r       <= {CNT_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      ce_r        <= 1'b0;
      sys_rst_n_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      acc_r       <= acc_nxt_s;
      ce_r        <= ce_nxt_s;
      sys_rst_n_r <= (state_nxt_s == RUN);
    end
  end

  assign sys_rst_n = sys_rst_n_r;
  assign ce        = ce_r;
  assign seq_state = state_r;

endmodule

// File: doc/clk_reset_seq.md
Name: clk_reset_seq

Overview:
- Sits directly downstream of the board PLL, clocked by the PLL output (54 MHz from the 18 MHz input).
- Qualifies PLL lock and the user reset button.
- Sequences a clean synchronous-release system reset for the PDP-11 core and Apple II bus logic.
- Generates a fractional-rate clock-enable strobe, default 1 MHz, for bus-timed logic.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronized lock required before reset sequencing proceeds (>=1).
- RESET_HOLD_CYCLES, 16: cycles sys_rst_n is held low with ce running before release (>=1).
- CE_NUM, 1: clock-enable rate numerator (1 <= CE_NUM <= CE_DEN).
- CE_DEN, 54: clock-enable rate denominator; ce rate = clk * CE_NUM / CE_DEN.
- DEBOUNCE_CYCLES, 65536: button filter length; used only with the optional feature.

Ports:
- clk, input, 1: PLL output clock.
- rst_n, input, 1: asynchronous active-low reset.
- pll_lock, input, 1: PLL lock, asynchronous to clk.
- btn_rst_n, input, 1: user reset button, active-low, asynchronous.
- sys_rst_n, output, 1: registered system reset, active-low.
- ce, output, 1: registered single-cycle clock-enable pulse.
- seq_state, output, 2: current FSM state (0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN).

Behaviour:
- Reset: clock is clk, reset is rst_n, asynchronous active-low. On rst_n low, all flops clear immediately:
  - state = WAIT_LOCK, counters = 0, accumulator = 0.
  - sys_rst_n = 0, ce = 0, seq_state = 0.
- Input synchronization: pll_lock and btn_rst_n each pass through a 2-flop synchronizer giving lock_s and btn_s. Synchronizer flops reset to 0 and 1 respectively.
- FSM, one shared counter cnt of width clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)):
  - WAIT_LOCK: cnt = 0. If lock_s = 1, go to STABLE.
  - STABLE: if lock_s = 0, go to WAIT_LOCK. Else if cnt == LOCK_STABLE_CYCLES-1, go to HOLD with cnt = 0. Else cnt++.
  - HOLD: if lock_s = 0, go to WAIT_LOCK. Else if btn_s = 0, cnt = 0 and stay. Else if cnt == RESET_HOLD_CYCLES-1, go to RUN. Else cnt++.
  - RUN: if lock_s = 0, go to WAIT_LOCK. Else if btn_s = 0, go to HOLD with cnt = 0.
- Priority: lock loss beats button in every state.
- sys_rst_n is registered and equals 1 exactly while state == RUN. It deasserts on the same edge the FSM leaves RUN.
- Clock enable:
  - Accumulator acc has width clog2(CE_DEN)+1 and is active only in HOLD and RUN.
  - Each active cycle: sum = acc + CE_NUM. If sum >= CE_DEN, then acc = sum - CE_DEN and ce = 1; else acc = sum and ce = 0.
  - In WAIT_LOCK and STABLE: acc = 0, ce = 0.
  - acc clears on entry to HOLD from STABLE. acc is NOT cleared on RUN->HOLD (button), so the strobe phase is continuous.
- Timing: number edges with edge 1 = first edge sampling pll_lock = 1.
  - lock_s goes high after edge 2; FSM enters STABLE after edge 3.
  - HOLD after edge 3+L; RUN and sys_rst_n = 1 after edge 3+L+H (L = LOCK_STABLE_CYCLES, H = RESET_HOLD_CYCLES).
- CE_NUM == CE_DEN gives ce = 1 on every active cycle.

Optional Feature:
- Macro: BTN_DEBOUNCE_EN.
- Defined: btn_s feeds a debounce filter. The filtered level changes only after DEBOUNCE_CYCLES consecutive identical btn_s samples; any mismatch restarts the count. The filter resets to 1 (released). The FSM uses the filtered level.
- Undefined: the FSM uses btn_s directly, the DEBOUNCE_CYCLES counter is absent, and a one-cycle btn_s low restarts HOLD.

Test Plan (L=8, H=4, CE_NUM=3, CE_DEN=8, no debounce):
1. Raise pll_lock once -> seq_state 0->1->2->3; sys_rst_n = 1 after edge 15. ce = 0 before HOLD; then ce is high on the 3rd, 6th and 8th cycle of every 8 from HOLD entry (3 pulses per 8).
2. Drop pll_lock for 1 sampled cycle at STABLE cnt = 5 -> return to WAIT_LOCK, cnt cleared. After relock, the full 8 + 4 cycles are required again.
3. In RUN, pulse btn_rst_n low 3 cycles -> sys_rst_n low from 2 edges after the first low sample. HOLD restarts each low cycle; sys_rst_n returns high 4 cycles after btn_s goes high. ce phase is unbroken.
4. In RUN, drop pll_lock and btn_rst_n on the same edge -> state goes to WAIT_LOCK (not HOLD); ce = 0 and acc = 0 next cycle.
5. Assert rst_n low mid-HOLD, off any clock edge -> sys_rst_n = 0, ce = 0, seq_state = 0 immediately, without a clock edge. After release, sequencing restarts from WAIT_LOCK.
6. With BTN_DEBOUNCE_EN and DEBOUNCE_CYCLES = 4: a 3-cycle button glitch in RUN -> no effect. A 5-cycle press -> HOLD entered after the 4th stable low sample.
